// File: rtl/dec_share_arb.sv
// Round-robin arbiter sharing one decrement unit (d = a - 1) among NUM_REQ requesters.
// Optional macro DEC_SHARE_SAT_EN: saturating decrement plus an rsp_uflow output.
module dec_share_arb #(
  parameter int DATAWIDTH = 64,
  parameter int NUM_REQ   = 4,
  parameter int IDW       = 2
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATAWIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATAWIDTH-1:0]         rsp_data,
  output logic [IDW-1:0]               rsp_id
`ifdef DEC_SHARE_SAT_EN
  ,
  output logic                         rsp_uflow
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic [IDW-1:0]         ptr_r;
  logic [IDW-1:0]         grant_s;
  logic                   any_s;
  logic                   take_s;
  logic [DATAWIDTH-1:0]   op_s;

  function automatic logic [DATAWIDTH-1:0] dec_f(input logic [DATAWIDTH-1:0] a);
`ifdef DEC_SHARE_SAT_EN
    return (a == {DATAWIDTH{1'b0}}) ? {DATAWIDTH{1'b0}} : a - {{(DATAWIDTH-1){1'b0}}, 1'b1};
`else
    return a - {{(DATAWIDTH-1){1'b0}}, 1'b1};
`endif
  endfunction

  // Round-robin search starting just after the last granted index.
  always_comb begin
    any_s   = 1'b0;
    take_s  = 1'b0;
    grant_s = {IDW{1'b0}};
    for (int k = 1; k <= NUM_REQ; k++) begin
      take_s  = !any_s && req_valid[(int'(ptr_r) + k) % NUM_REQ];
      grant_s = take_s ? IDW'((int'(ptr_r) + k) % NUM_REQ) : grant_s;
      any_s   = any_s | take_s;
    end
  end

  assign op_s = req_data[int'(grant_s)*DATAWIDTH +: DATAWIDTH];

  // Next-state and grant decode; the grant is masked while reset is held.
  always_comb begin
    state_s   = state_r;
    req_ready = {NUM_REQ{1'b0}};
    case (state_r)
      IDLE: begin
        if (any_s && Rst) begin
          req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_s;
          state_s   = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = BUSY;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Result capture on grant, release on response handshake.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= {DATAWIDTH{1'b0}};
      rsp_id    <= {IDW{1'b0}};
      ptr_r     <= IDW'(NUM_REQ - 1);
`ifdef DEC_SHARE_SAT_EN
      rsp_uflow <= 1'b0;
`endif
    end else if (state_r == IDLE && any_s) begin
      rsp_valid <= 1'b1;
      rsp_data  <= dec_f(op_s);
      rsp_id    <= grant_s;
      ptr_r     <= grant_s;
`ifdef DEC_SHARE_SAT_EN
      rsp_uflow <= (op_s == {DATAWIDTH{1'b0}});
`endif
    end else if (state_r == BUSY && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dec_share_arb.sv
// Scoreboard bench for dec_share_arb: a reference arbiter pushes expected results on grant,
// responses are popped and compared on handshake; directed checks cover the test plan.
module tb_dec_share_arb;
  localparam int DW = 64;
  localparam int NR = 4;
  localparam int IW = 2;

  logic            Clk = 1'b0;
  logic            Rst = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]   req_ready;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [DW-1:0]   rsp_data;
  logic [IW-1:0]   rsp_id;
`ifdef DEC_SHARE_SAT_EN
  logic            rsp_uflow;
`endif

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    logic          uf;
    int            cyc;
  } item_t;

  item_t sb[$];
  item_t obs[$];
  item_t mit;
  item_t pit;
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  bit    m_busy = 1'b0;
  int    m_ptr = NR - 1;
  int    mg;
  bit    mfound;
  logic [DW-1:0] mop;

  dec_share_arb #(.DATAWIDTH(DW), .NUM_REQ(NR), .IDW(IW)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
`ifdef DEC_SHARE_SAT_EN
    ,
    .rsp_uflow (rsp_uflow)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_dec(input logic [DW-1:0] a);
`ifdef DEC_SHARE_SAT_EN
    return (a == 64'd0) ? 64'd0 : a - 64'd1;
`else
    return a - 64'd1;
`endif
  endfunction

  task automatic set_op(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  // Reference arbiter and scoreboard, sampled just before each rising edge.
  always @(negedge Clk) begin
    #4;
    cyc++;
    if (!Rst) begin
      m_busy = 1'b0;
      m_ptr  = NR - 1;
      sb.delete();
    end else if (!m_busy) begin
      mfound = 1'b0;
      mg = 0;
      for (int k = 1; k <= NR; k++) begin
        if (!mfound && req_valid[(m_ptr + k) % NR]) begin
          mfound = 1'b1;
          mg = (m_ptr + k) % NR;
        end
      end
      check("idle_valid", 64'(rsp_valid), 64'd0);
      if (mfound) begin
        check("grant", 64'(req_ready), 64'd1 << mg);
        mop = req_data[mg*DW +: DW];
        mit.id = mg;
        mit.data = exp_dec(mop);
        mit.uf = (mop == 64'd0);
        mit.cyc = cyc;
        sb.push_back(mit);
        m_ptr = mg;
        m_busy = 1'b1;
      end else begin
        check("idle_ready", 64'(req_ready), 64'd0);
      end
    end else begin
      check("busy_ready", 64'(req_ready), 64'd0);
      check("busy_valid", 64'(rsp_valid), 64'd1);
      if (rsp_ready) begin
        check("sb_pop", 64'(sb.size()), 64'd1);
        if (sb.size() > 0) begin
          pit = sb.pop_front();
          check("sb_id", 64'(rsp_id), 64'(pit.id));
          check("sb_data", rsp_data, pit.data);
`ifdef DEC_SHARE_SAT_EN
          check("sb_uflow", 64'(rsp_uflow), 64'(pit.uf));
`endif
        end
        mit.id = int'(rsp_id);
        mit.data = rsp_data;
        mit.uf = 1'b0;
        mit.cyc = cyc;
        obs.push_back(mit);
        m_busy = 1'b0;
      end
    end
  end

  initial begin
    // Reset state, grant masked while reset is held even with all requesters valid
    req_valid = 4'b1111;
    #1;
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_data", rsp_data, 64'd0);
    check("rst_id", 64'(rsp_id), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    repeat (2) @(negedge Clk);
    req_valid = 4'b0000;
    Rst = 1'b1;

    // Single requester
    set_op(2, 64'd10);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1 check("t2_grant", 64'(req_ready), 64'b0100);
    @(negedge Clk);
    req_valid = 4'b0000;
    #1;
    check("t2_valid", 64'(rsp_valid), 64'd1);
    check("t2_data", rsp_data, 64'd9);
    check("t2_id", 64'(rsp_id), 64'd2);
    check("t2_ready", 64'(req_ready), 64'd0);
    @(negedge Clk);
    #1 check("t2_drop", 64'(rsp_valid), 64'd0);

    // Reset mid-transaction
    @(negedge Clk);
    set_op(0, 64'd7);
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    @(negedge Clk);
    req_valid = 4'b0000;
    #1 check("t1_busy", 64'(rsp_valid), 64'd1);
    #1 Rst = 1'b0;
    set_op(0, 64'd100);
    set_op(1, 64'd200);
    set_op(2, 64'd300);
    set_op(3, 64'd400);
    req_valid = 4'b1111;
    #1;
    check("t1_valid", 64'(rsp_valid), 64'd0);
    check("t1_data", rsp_data, 64'd0);
    check("t1_ready", 64'(req_ready), 64'd0);
    @(negedge Clk);
    Rst = 1'b1;
    rsp_ready = 1'b1;
    obs.delete();
    #1 check("t1_first", 64'(req_ready), 64'b0001);

    // Round-robin fairness with all requesters valid
    repeat (10) @(negedge Clk);
    req_valid = 4'b0000;
    check("t3_count", 64'(obs.size()), 64'd5);
    if (obs.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        check("t3_id", 64'(obs[i].id), 64'(i % 4));
        check("t3_data", obs[i].data, 64'((i % 4 + 1) * 100 - 1));
        if (i > 0) check("t3_gap", 64'(obs[i].cyc - obs[i-1].cyc), 64'd2);
      end
    end

    // Backpressure with requester 1 valid throughout
    obs.delete();
    rsp_ready = 1'b0;
    set_op(1, 64'd55);
    req_valid = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      #1;
      check("t4_valid", 64'(rsp_valid), 64'd1);
      check("t4_data", rsp_data, 64'd54);
      check("t4_id", 64'(rsp_id), 64'd1);
      check("t4_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge Clk);
    #1;
    check("t4_regrant", 64'(req_ready), 64'b0010);
    check("t4_idle", 64'(rsp_valid), 64'd0);
    @(negedge Clk);
    req_valid = 4'b0000;
    @(negedge Clk);
    check("t4_count", 64'(obs.size()), 64'd2);

    // Underflow, then an ordinary operand on the same requester
    set_op(3, 64'd0);
    req_valid = 4'b1000;
    @(negedge Clk);
    req_valid = 4'b0000;
    #1;
`ifdef DEC_SHARE_SAT_EN
    check("t5_sat", rsp_data, 64'd0);
    check("t5_uflow", 64'(rsp_uflow), 64'd1);
`else
    check("t5_wrap", rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
    @(negedge Clk);
    set_op(3, 64'd5);
    req_valid = 4'b1000;
    @(negedge Clk);
    req_valid = 4'b0000;
    #1;
    check("t5_data", rsp_data, 64'd4);
`ifdef DEC_SHARE_SAT_EN
    check("t5_nouflow", 64'(rsp_uflow), 64'd0);
`endif
    @(negedge Clk);

    // Withdrawn request: requester 2 appears only while BUSY
    obs.delete();
    rsp_ready = 1'b0;
    set_op(1, 64'd30);
    req_valid = 4'b0010;
    @(negedge Clk);
    set_op(2, 64'd40);
    req_valid = 4'b0110;
    @(negedge Clk);
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    @(negedge Clk);
    #1 check("t6_grant", 64'(req_ready), 64'b0010);
    @(negedge Clk);
    req_valid = 4'b0000;
    repeat (3) @(negedge Clk);
    check("t6_count", 64'(obs.size()), 64'd2);
    if (obs.size() == 2) begin
      for (int i = 0; i < 2; i++) begin
        check("t6_id", 64'(obs[i].id), 64'd1);
        check("t6_data", obs[i].data, 64'd29);
      end
    end

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dec_share_arb.md
Name: dec_share_arb

Overview:
- Round-robin scheduler that shares one DATAWIDTH-bit decrement datapath (d = a - 1) among NUM_REQ requesters.
- Used by HLS-generated schedules that bind several decrement operations to a single functional unit.
- Grants one requester per transaction, registers the decremented result with the requester ID, and holds it until the consumer accepts it.

Parameters:
- DATAWIDTH, 64, operand/result width in bits.
- NUM_REQ, 4, number of requesters (2..16).
- IDW, 2, width of requester ID. Must satisfy 2^IDW >= NUM_REQ.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-low reset (0 = reset).
- req_valid  input  NUM_REQ  bit i: requester i presents an operand.
- req_data  input  NUM_REQ*DATAWIDTH  operand of requester i in bits [i*DATAWIDTH +: DATAWIDTH].
- req_ready  output  NUM_REQ  one-hot grant. Bit i high means requester i's operand is captured at this edge.
- rsp_valid  output  1  registered result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  DATAWIDTH  decremented operand.
- rsp_id  output  IDW  index of the requester that produced rsp_data.

Behaviour:
- Reset (Rst=0, asynchronous, any state):
  - state = IDLE.
  - rsp_valid = 0, rsp_data = 0, rsp_id = 0.
  - last-grant pointer = NUM_REQ-1, so requester 0 has first priority.
  - req_ready = 0 while in reset.
  - Any in-flight result is discarded.
- States: IDLE, BUSY.
- IDLE:
  - If any req_valid is high, select g = first asserted index searching from pointer+1 upward, modulo NUM_REQ.
  - req_ready is combinational, one-hot at bit g, and asserted only in IDLE.
  - At the clock edge:
    - capture rsp_data <= req_data[g] - 1 (DATAWIDTH bits, modular);
    - capture rsp_id <= g;
    - pointer <= g;
    - rsp_valid <= 1;
    - state <= BUSY.
  - If no req_valid is high: req_ready = 0 and the state stays IDLE.
- BUSY:
  - req_ready = 0.
  - rsp_valid, rsp_data and rsp_id are held stable until rsp_ready = 1.
  - On rsp_valid & rsp_ready at an edge: rsp_valid <= 0 and state <= IDLE.
  - rsp_data and rsp_id keep their last values; they are don't-care while rsp_valid = 0.
- Timing:
  - Latency from grant edge to rsp_valid high is 1 cycle.
  - Maximum throughput is one transaction per 2 cycles.
  - The grant is not reissued in the same cycle as the response handshake.
- Requesters must hold req_valid and req_data stable until granted. Deasserting req_valid before the grant withdraws the request with no side effects.
- Arithmetic: 0 - 1 wraps to all ones (2^DATAWIDTH - 1). No carry or borrow output is produced.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,NUM_REQ-1,0,...
- Starvation bound: a requester held valid is granted within NUM_REQ transactions.
- Reset released while req_valid is high: the first grant goes to index 0 if it is requesting.

Optional Feature:
- Macro: DEC_SHARE_SAT_EN.
- When defined:
  - the decrement saturates: an operand of 0 yields rsp_data = 0;
  - an extra output port `rsp_uflow` (1 bit) is added. It is set with rsp_data when the operand was 0, otherwise 0, and reset value is 0.
- When undefined:
  - the decrement wraps modularly;
  - the rsp_uflow port does not exist.

Test Plan:
1. Reset mid-transaction:
   - Setup: reach BUSY with rsp_valid=1 and rsp_ready=0.
   - Stimulus: drive Rst=0 between clock edges.
   - Expected: rsp_valid=0 and rsp_data=0 immediately. After release, req_valid=4'b1111 grants index 0 first.
2. Single requester:
   - Stimulus: req_valid=4'b0100, req_data[2]=64'd10, rsp_ready=1.
   - Expected: req_ready=4'b0100 for one cycle. Next cycle rsp_valid=1, rsp_data=9, rsp_id=2. rsp_valid=0 the following cycle.
3. Round-robin fairness:
   - Stimulus: all four valid with operands 100, 200, 300, 400; rsp_ready=1.
   - Expected: rsp_id sequence 0,1,2,3,0 and rsp_data 99,199,299,399,99, one result every 2 cycles.
4. Backpressure:
   - Stimulus: rsp_ready=0 for 5 cycles after a grant, with requester 1 valid throughout.
   - Expected: rsp_valid, rsp_data and rsp_id stay stable; req_ready=0 for all 5 cycles; requester 1 is granted only after rsp_ready=1 and the return to IDLE.
5. Underflow:
   - Stimulus: operand 0 on requester 3.
   - Expected without DEC_SHARE_SAT_EN: rsp_data=64'hFFFF_FFFF_FFFF_FFFF.
   - Expected with DEC_SHARE_SAT_EN: rsp_data=0 and rsp_uflow=1. A following operand 5 gives rsp_data=4 and rsp_uflow=0.
6. Withdrawn request:
   - Stimulus: requester 2 valid while BUSY, then deasserted before the return to IDLE; requester 1 still valid.
   - Expected: the next grant goes to 1, and requester 2 is never granted.
